// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Holds the fetch FSM state encoding, the fetch-buffer entry layout and
// the default PC / instruction widths used by fetch_unit and its bench.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  // Entry layout, MSB first. fetch_unit packs its buffer words in this order.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0] pc;
    logic                  fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_buf.sv
// fetch_buf: parameterised synchronous FIFO with a synchronous clear.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push is dropped only when full with no pop; push+pop allowed at any occupancy.
//
// Ports: clk, rst_n (async active-low), clr (empties next cycle, wins over push/pop),
//        push/push_dat, pop, head_dat (zero when empty), count (occupancy), empty.
module fetch_buf #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign do_push  = push & (~full | do_pop);
  // Zeroed when empty so the decode side sees clean zeros after reset/clear.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues single-outstanding instruction-memory reads at pc and buffers results for decode.
// Latency: instr_valid rises 1 cycle after imem_rvalid; request issued 1 cycle after buffer space appears.
// Backpressure: stops requesting while occupancy + outstanding reaches BUF_DEPTH; flush empties the buffer.
//
// Ports: clk, rst_n (async active-low); pc in / pc_en out (PC register advance or redirect load);
//        flush (redirect); imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata (memory side);
//        instr_valid/instr/instr_pc/instr_fault/instr_ready (decode side).
// Option: FETCH_MISALIGN_CHK_EN turns a misaligned pc into a fault entry instead of a memory read.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_fault,
  input  logic              instr_ready
);

  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int ENTRY_W = DATA_W + ADDR_W + 1;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  fetch_state_t        state_q;
  fetch_state_t        state_d;
  logic [ADDR_W-1:0]   fetch_pc_q;
  logic [CNT_W-1:0]    buf_count;
  logic                buf_empty;
  logic [ENTRY_W-1:0]  head_dat;
  logic [ENTRY_W-1:0]  push_dat;
  logic                outstanding;
  logic                has_room;
  logic                misalign;
  logic                req_gnt;
  logic                rsp_push;
  logic                fault_push;
  logic                buf_push;
  logic                buf_pop;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign outstanding = (state_q == ST_WAIT) || (state_q == ST_DROP);
  assign has_room    = (buf_count + CNT_W'(outstanding)) < CNT_W'(BUF_DEPTH);
  assign req_gnt     = imem_req & imem_gnt;
  assign imem_addr   = pc;

  // Reset gates the flush term so the PC register stays put while in reset.
  assign pc_en = req_gnt | (flush & rst_n) | fault_push;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!flush && has_room) state_d = ST_REQ;
      ST_REQ: begin
        // A grant coinciding with flush still owes us a response: wait it out in DROP.
        if (flush)         state_d = req_gnt ? ST_DROP : ST_IDLE;
        else if (misalign) state_d = ST_IDLE;
        else if (req_gnt)  state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rvalid) state_d = ST_IDLE;
        else if (flush)  state_d = ST_DROP;
      end
      ST_DROP: if (imem_rvalid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req   = 1'b0;
    fault_push = 1'b0;
    rsp_push   = 1'b0;
    case (state_q)
      ST_REQ: begin
        imem_req   = ~misalign;
        fault_push = misalign;
      end
      ST_WAIT: rsp_push = imem_rvalid;
      default: ;
    endcase
  end

  // The PC register advances on the grant, so capture the address being fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fetch_pc_q <= '0;
    else if (req_gnt) fetch_pc_q <= pc;
  end

  // Anything produced in the flush cycle belongs to the abandoned path.
  assign buf_push = (rsp_push | fault_push) & ~flush;
  assign push_dat = fault_push ? {{DATA_W{1'b0}}, pc, 1'b1}
                               : {imem_rdata, fetch_pc_q, 1'b0};
  assign buf_pop  = instr_valid & instr_ready;

  fetch_buf #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .push     (buf_push),
    .push_dat (push_dat),
    .pop      (buf_pop),
    .head_dat (head_dat),
    .count    (buf_count),
    .empty    (buf_empty)
  );

  assign instr_valid = ~buf_empty;
  assign instr       = head_dat[ENTRY_W-1 -: DATA_W];
  assign instr_pc    = head_dat[ADDR_W:1];
  assign instr_fault = head_dat[0] & MISALIGN_EN;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with randomised memory
// latency, grant and ready, checked against a program-order model of the decode stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int UNLIMITED = 100000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc;
  logic          pc_en;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_fault;
  logic          instr_ready;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_en       (pc_en),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Environment knobs
  int grants_left, gnt_pct, lat_min, lat_max, ready_mode;
  // Memory model
  logic          mem_pend;
  int            mem_cnt;
  logic [AW-1:0] mem_addr;
  // Per-cycle history
  logic          pc_en_prev, flush_prev, hold_prev, req_wait_prev;
  logic [AW-1:0] tgt_prev;
  fetch_entry_t  head_prev;
  // Program-order model: next pc decode must receive
  logic [AW-1:0] exp_pc;
  int            pc_en_cnt, req_cnt, grant_cnt, pops;
  logic          gnt_evt, rvalid_evt, seen_dead, found;
  logic [AW-1:0] gnt_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == AW'(0)) return 32'h00500093;
    if (a == AW'(8)) return 32'hDEADBEEF;
    return {5'h0, a, 16'hC0DE} ^ 32'h13;
  endfunction

  function automatic fetch_entry_t exp_entry(input logic [AW-1:0] a);
    fetch_entry_t e;
    e.instr = mem_word(a);
    e.pc    = a;
    e.fault = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    if (a[1:0] != 2'b00) begin
      e.instr = '0;
      e.fault = 1'b1;
    end
`endif
    return e;
  endfunction

  // One clock cycle: update PC register and memory, drive inputs, check outputs.
  task automatic step(input logic do_flush, input logic [AW-1:0] tgt);
    logic exp_pc_en;
    @(negedge clk);
    if (pc_en_prev) pc = flush_prev ? tgt_prev : pc + AW'(4);
    rvalid_evt  = 1'b0;
    gnt_evt     = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pend    = 1'b0;
        rvalid_evt  = 1'b1;
      end else begin
        mem_cnt--;
      end
    end
    flush = do_flush;
    case (ready_mode)
      0:       instr_ready = 1'b0;
      1:       instr_ready = 1'b1;
      default: instr_ready = ($urandom_range(1, 0) == 1);
    endcase
    imem_gnt = 1'b0;
    #1;
    if (imem_req && grants_left > 0 && ($urandom_range(99, 0) < gnt_pct)) imem_gnt = 1'b1;
    #1;
    exp_pc_en = (imem_req & imem_gnt) | flush;
`ifdef FETCH_MISALIGN_CHK_EN
    if (pc[1:0] == 2'b00) chk("pc_en_rule", 64'(pc_en), 64'(exp_pc_en));
`else
    chk("pc_en_rule", 64'(pc_en), 64'(exp_pc_en));
`endif
    if (imem_req) chk("imem_addr_is_pc", 64'(imem_addr), 64'(pc));
    if (req_wait_prev) chk("req_held_until_gnt", 64'(imem_req), 64'(1));
    if (imem_req) req_cnt++;
    if (pc_en) pc_en_cnt++;
    if (imem_req && imem_gnt) begin
      chk("one_outstanding", 64'(mem_pend), 64'(0));
      mem_pend  = 1'b1;
      mem_addr  = imem_addr;
      mem_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
      gnt_evt   = 1'b1;
      gnt_addr  = imem_addr;
      grant_cnt++;
      grants_left--;
    end
    if (flush_prev) chk("flush_empties", 64'(instr_valid), 64'(0));
    if (hold_prev && !flush_prev)
      chk("head_stable", 64'({instr, instr_pc, instr_fault}), 64'(head_prev));
    if (instr_valid && instr == 32'hDEADBEEF) seen_dead = 1'b1;
    if (instr_valid && instr_ready) begin
      chk("stream_entry", 64'({instr, instr_pc, instr_fault}), 64'(exp_entry(exp_pc)));
      exp_pc = exp_pc + AW'(4);
      pops++;
    end
    if (flush) exp_pc = tgt;
    hold_prev     = instr_valid & ~instr_ready;
    head_prev     = {instr, instr_pc, instr_fault};
    pc_en_prev    = pc_en;
    flush_prev    = flush;
    tgt_prev      = tgt;
    req_wait_prev = imem_req & ~imem_gnt & ~flush;
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; flush = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0;
    grants_left = 0; gnt_pct = 100; lat_min = 1; lat_max = 1; ready_mode = 0;
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
    pc_en_prev = 1'b0; flush_prev = 1'b0; hold_prev = 1'b0; req_wait_prev = 1'b0;
    tgt_prev = '0; head_prev = '0; exp_pc = '0;
    pc_en_cnt = 0; req_cnt = 0; grant_cnt = 0; pops = 0;
    gnt_evt = 1'b0; rvalid_evt = 1'b0; seen_dead = 1'b0; found = 1'b0; gnt_addr = '0;

    // Reset state (flush held high to show pc_en stays low in reset)
    repeat (2) @(negedge clk);
    #1;
    chk("rst_instr_valid", 64'(instr_valid), 64'(0));
    chk("rst_imem_req", 64'(imem_req), 64'(0));
    chk("rst_pc_en", 64'(pc_en), 64'(0));
    chk("rst_instr", 64'(instr), 64'(0));
    chk("rst_instr_pc", 64'(instr_pc), 64'(0));
    chk("rst_instr_fault", 64'(instr_fault), 64'(0));
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single fetch from 0x000
    grants_left = 1; pc_en_cnt = 0; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, '0);
      if (rvalid_evt) found = 1'b1;
    end
    chk("single_rvalid_seen", 64'(found), 64'(1));
    chk("single_not_valid_yet", 64'(instr_valid), 64'(0));
    step(1'b0, '0);
    chk("single_valid", 64'(instr_valid), 64'(1));
    chk("single_instr", 64'(instr), 64'(32'h00500093));
    chk("single_instr_pc", 64'(instr_pc), 64'(0));
    repeat (3) step(1'b0, '0);
    chk("single_pc_en_once", 64'(pc_en_cnt), 64'(1));
    ready_mode = 1; pops = 0;
    step(1'b0, '0);
    chk("single_popped", 64'(pops), 64'(1));

    // Back-pressure: decode stalled, six fetches offered
    ready_mode = 0;
    step(1'b1, '0);
    pc_en_cnt = 0; grant_cnt = 0; grants_left = 6;
    repeat (30) step(1'b0, '0);
    chk("bp_grants", 64'(grant_cnt), 64'(2));
    chk("bp_pc_en_twice", 64'(pc_en_cnt), 64'(2));
    chk("bp_valid", 64'(instr_valid), 64'(1));
    chk("bp_head_pc", 64'(instr_pc), 64'(0));
    req_cnt = 0;
    repeat (5) step(1'b0, '0);
    chk("bp_req_low", 64'(req_cnt), 64'(0));
    grants_left = 0; ready_mode = 1; pops = 0;
    repeat (6) step(1'b0, '0);
    chk("bp_drained_two", 64'(pops), 64'(2));
    chk("bp_empty", 64'(instr_valid), 64'(0));

    // Flush while waiting for the 0x008 response
    lat_min = 4; lat_max = 4; grants_left = UNLIMITED;
    step(1'b1, '0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, '0);
      if (gnt_evt && gnt_addr == AW'(8)) found = 1'b1;
    end
    chk("fw_gnt_008_seen", 64'(found), 64'(1));
    step(1'b1, AW'(12'h040));
    seen_dead = 1'b0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      if (rvalid_evt) found = 1'b1;
    end
    chk("fw_rvalid_seen", 64'(found), 64'(1));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      if (gnt_evt) found = 1'b1;
    end
    chk("fw_next_gnt_seen", 64'(found), 64'(1));
    chk("fw_redirect_addr", 64'(gnt_addr), 64'(12'h040));
    repeat (10) step(1'b0, '0);
    chk("fw_no_deadbeef", 64'(seen_dead), 64'(0));

    // Flush coinciding with a grant
    lat_min = 2; lat_max = 3; grants_left = 0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, '0);
      if (imem_req) found = 1'b1;
    end
    chk("fg_req_seen", 64'(found), 64'(1));
    grants_left = 1;
    step(1'b1, AW'(12'h080));
    chk("fg_gnt_taken", 64'(gnt_evt), 64'(1));
    chk("fg_pc_en", 64'(pc_en), 64'(1));
    req_cnt = 0; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, '0);
      if (rvalid_evt) found = 1'b1;
    end
    chk("fg_rvalid_seen", 64'(found), 64'(1));
    chk("fg_no_req_in_drop", 64'(req_cnt), 64'(0));
    step(1'b0, '0);
    chk("fg_data_dropped", 64'(instr_valid), 64'(0));
    grants_left = UNLIMITED; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, '0);
      if (gnt_evt) found = 1'b1;
    end
    chk("fg_next_gnt_seen", 64'(found), 64'(1));
    chk("fg_redirect_addr", 64'(gnt_addr), 64'(12'h080));

    // Streaming: 1-cycle memory, decode always ready
    lat_min = 1; lat_max = 1;
    step(1'b1, '0);
    pops = 0;
    for (int i = 0; i < 200 && pops < 16; i++) step(1'b0, '0);
    chk("stream_16_instr", 64'(pops), 64'(16));

    // Randomised soak with occasional redirects
    gnt_pct = 60; lat_min = 1; lat_max = 3; ready_mode = 2; pops = 0;
    for (int i = 0; i < 400; i++)
      step($urandom_range(39, 0) == 0, AW'($urandom_range(511, 0) * 4));
    chk("soak_progress", 64'(pops > 10), 64'(1));

    // Misaligned pc handling
    gnt_pct = 100; lat_min = 1; lat_max = 1;
`ifdef FETCH_MISALIGN_CHK_EN
    grants_left = 0; ready_mode = 0;
    step(1'b1, AW'(2));
    req_cnt = 0;
    repeat (10) step(1'b0, '0);
    chk("mis_no_req", 64'(req_cnt), 64'(0));
    chk("mis_valid", 64'(instr_valid), 64'(1));
    chk("mis_fault", 64'(instr_fault), 64'(1));
    chk("mis_instr_pc", 64'(instr_pc), 64'(2));
    chk("mis_instr", 64'(instr), 64'(0));
    ready_mode = 1;
    repeat (4) step(1'b0, '0);
`else
    grants_left = UNLIMITED; ready_mode = 0;
    step(1'b1, AW'(2));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      if (instr_valid) found = 1'b1;
    end
    chk("unal_valid_seen", 64'(found), 64'(1));
    chk("unal_instr_pc", 64'(instr_pc), 64'(2));
    chk("unal_fault_zero", 64'(instr_fault), 64'(0));
    ready_mode = 1;
    repeat (4) step(1'b0, '0);
`endif

    // Reset in the middle of an outstanding read
    lat_min = 5; lat_max = 5; grants_left = UNLIMITED; ready_mode = 1;
    step(1'b1, '0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, '0);
      if (gnt_evt) found = 1'b1;
    end
    chk("rstmid_gnt_seen", 64'(found), 64'(1));
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    mem_pend = 1'b0; pc = '0; exp_pc = '0;
    pc_en_prev = 1'b0; flush_prev = 1'b0; hold_prev = 1'b0; req_wait_prev = 1'b0;
    #1;
    chk("rstmid_req_low", 64'(imem_req), 64'(0));
    chk("rstmid_valid_low", 64'(instr_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h12345678;
    grants_left = 0; found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0);
      if (instr_valid) found = 1'b1;
    end
    chk("rstmid_stray_ignored", 64'(found), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
